// File: rtl/exec_unit_dtypes.sv
// Shared exec-unit interconnect types: channel payloads, widths and the
// output-slot state encoding used by the icon arbiter.
`ifndef NUM_EXEC_UNITS
`define NUM_EXEC_UNITS 4
`endif

package exec_unit_dtypes;

   localparam int DATA_WIDTH   = 32;
   localparam int ADDR_WIDTH   = 16;
   localparam int LOG2_NUM_REQ = $clog2(`NUM_EXEC_UNITS);

   typedef struct packed {
      logic                  valid;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } type_icon_channel;

   typedef struct packed {
      logic ready;
   } type_icon_rx_channel;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } type_icon_arb_state;

endpackage

// File: rtl/eu_icon_arbiter_rr_priority_picker.sv
// Combinational round-robin search: first set request at or after the
// pointer, wrapping from NUM_REQ-1 back to 0.
module rr_priority_picker #(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic               o_found,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDX_W-1:0]   o_idx
);

   always_comb begin
      int               j;
      logic [IDX_W-1:0] w_pos;
      // NOTE: every output gets a default before the search so no path
      // leaves a value unassigned and no latch is inferred.
      o_found = 1'b0;
      o_grant = '0;
      o_idx   = '0;
      j       = 0;
      w_pos   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(i_ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         w_pos = IDX_W'(j);
         if (!o_found && i_req[w_pos]) begin
            o_found        = 1'b1;
            o_grant[w_pos] = 1'b1;
            o_idx          = w_pos;
         end
      end
   end

endmodule

// File: rtl/eu_icon_arbiter.sv
// Round-robin arbiter feeding one registered interconnect slot; the slot
// reloads in the same cycle it drains, giving one beat per cycle.
module eu_icon_arbiter
   import exec_unit_dtypes::*;
#(
   parameter  int NUM_REQ    = `NUM_EXEC_UNITS,
   parameter  int DATA_WIDTH = exec_unit_dtypes::DATA_WIDTH,
   localparam int IDX_W      = $clog2(NUM_REQ)
) (
   input  logic                i_clk,
   input  logic                reset,
   input  type_icon_channel    i_req [NUM_REQ],
   output logic [NUM_REQ-1:0]  o_req_ready,
   output type_icon_channel    o_chan,
   input  type_icon_rx_channel i_chan_rx,
   output logic [IDX_W-1:0]    o_grant_idx
);

   type_icon_arb_state r_state;
   type_icon_channel   r_chan;
   logic [IDX_W-1:0]   r_grant_idx;
   logic [IDX_W-1:0]   r_rr_ptr;

   logic [NUM_REQ-1:0] w_req_valid;
   logic               w_loadable;
   logic               w_found;
   logic [NUM_REQ-1:0] w_grant;
   logic [IDX_W-1:0]   w_sel_idx;
   logic [IDX_W-1:0]   w_next_ptr;

   always_comb begin
      w_req_valid = '0;
      for (int i = 0; i < NUM_REQ; i++) w_req_valid[i] = i_req[i].valid;
   end

   // Loadable when the slot is free or its current beat leaves this cycle.
   assign w_loadable = (r_state == EMPTY) || i_chan_rx.ready;

   rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .i_req   (w_req_valid),
      .i_ptr   (r_rr_ptr),
      .o_found (w_found),
      .o_grant (w_grant),
      .o_idx   (w_sel_idx)
   );

   assign w_next_ptr  = (w_sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_sel_idx + 1'b1;
   assign o_req_ready = (!reset && w_loadable && w_found) ? w_grant : '0;

   always_ff @(posedge i_clk) begin
      // NOTE: non-blocking assignments throughout, so every branch below
      // reads the pre-edge values of the slot registers.
      if (reset) begin
         r_state     <= EMPTY;
         r_chan      <= '0;
         r_grant_idx <= '0;
         r_rr_ptr    <= '0;
      end else if (w_loadable) begin
         if (w_found) begin
            r_chan.valid <= 1'b1;
            r_chan.addr  <= i_req[w_sel_idx].addr;
            r_chan.data  <= i_req[w_sel_idx].data[DATA_WIDTH-1:0];
            r_grant_idx  <= w_sel_idx;
            r_rr_ptr     <= w_next_ptr;
            r_state      <= FULL;
         end else begin
            r_chan.valid <= 1'b0;
            r_state      <= EMPTY;
         end
      end
   end

   assign o_chan      = r_chan;
   assign o_grant_idx = r_grant_idx;

endmodule

// File: tb/tb_eu_icon_arbiter.sv
// Scoreboard bench: drivers push expected beats, per-DUT monitors pop and
// compare on every completed output beat (o_chan.valid && ready).
module tb_eu_icon_arbiter;
   import exec_unit_dtypes::*;

   localparam int NA = 4;
   localparam int NB = 3;

   typedef struct {
      int                    idx;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;

   type_icon_channel    a_req [NA];
   logic [NA-1:0]       a_ready;
   type_icon_channel    a_chan;
   type_icon_rx_channel a_rx;
   logic [1:0]          a_idx;

   type_icon_channel    b_req [NB];
   logic [NB-1:0]       b_ready;
   type_icon_channel    b_chan;
   type_icon_rx_channel b_rx;
   logic [1:0]          b_idx;

   exp_t qa[$];
   exp_t qb[$];
   int   checks   = 0;
   int   failures = 0;

   eu_icon_arbiter #(.NUM_REQ(NA)) u_dut_a (
      .i_clk(clk), .reset(reset), .i_req(a_req), .o_req_ready(a_ready),
      .o_chan(a_chan), .i_chan_rx(a_rx), .o_grant_idx(a_idx));

   eu_icon_arbiter #(.NUM_REQ(NB)) u_dut_b (
      .i_clk(clk), .reset(reset), .i_req(b_req), .o_req_ready(b_ready),
      .o_chan(b_chan), .i_chan_rx(b_rx), .o_grant_idx(b_idx));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_a(input int i, input logic v, input logic [DATA_WIDTH-1:0] d);
      a_req[i].valid = v;
      a_req[i].addr  = 16'h0A00 + ADDR_WIDTH'(i);
      a_req[i].data  = d;
   endtask

   task automatic set_b(input int i, input logic v, input logic [DATA_WIDTH-1:0] d);
      b_req[i].valid = v;
      b_req[i].addr  = 16'h0B00 + ADDR_WIDTH'(i);
      b_req[i].data  = d;
   endtask

   task automatic push_a(input int i, input logic [DATA_WIDTH-1:0] d);
      exp_t e;
      e.idx  = i;
      e.addr = 16'h0A00 + ADDR_WIDTH'(i);
      e.data = d;
      qa.push_back(e);
   endtask

   task automatic push_b(input int i, input logic [DATA_WIDTH-1:0] d);
      exp_t e;
      e.idx  = i;
      e.addr = 16'h0B00 + ADDR_WIDTH'(i);
      e.data = d;
      qb.push_back(e);
   endtask

   // Monitors: a beat completes when valid and ready are both high.
   always @(negedge clk) begin
      exp_t e;
      if (!reset && a_chan.valid && a_rx.ready) begin
         if (qa.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL a_unexpected_beat: got idx %0d data %0h expected no beat", a_idx, a_chan.data);
         end else begin
            e = qa.pop_front();
            check("a_beat_idx", 64'(a_idx), 64'(e.idx));
            check("a_beat_data", 64'(a_chan.data), 64'(e.data));
            check("a_beat_addr", 64'(a_chan.addr), 64'(e.addr));
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!reset && b_chan.valid && b_rx.ready) begin
         if (qb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL b_unexpected_beat: got idx %0d data %0h expected no beat", b_idx, b_chan.data);
         end else begin
            e = qb.pop_front();
            check("b_beat_idx", 64'(b_idx), 64'(e.idx));
            check("b_beat_data", 64'(b_chan.data), 64'(e.data));
            check("b_beat_addr", 64'(b_chan.addr), 64'(e.addr));
         end
      end
   end

   initial begin
      reset = 1'b1;
      a_rx.ready = 1'b1;
      b_rx.ready = 1'b1;
      for (int i = 0; i < NA; i++) set_a(i, 1'b0, '0);
      for (int i = 0; i < NB; i++) set_b(i, 1'b0, '0);
      set_a(1, 1'b1, 32'h1111_0000);
      set_b(2, 1'b1, 32'h2222_0000);

      // Reset: requests present but no acceptance, slot cleared.
      step();
      check("rst_a_req_ready", 64'(a_ready), 64'(0));
      check("rst_b_req_ready", 64'(b_ready), 64'(0));
      step();
      check("rst_a_chan", 64'(a_chan), 64'(0));
      check("rst_a_grant_idx", 64'(a_idx), 64'(0));
      check("rst_b_chan", 64'(b_chan), 64'(0));
      set_a(1, 1'b0, '0);
      set_b(2, 1'b0, '0);
      reset = 1'b0;

      // Lone requester 2 for five cycles, new data each cycle.
      for (int k = 0; k < 5; k++) begin
         set_a(2, 1'b1, 32'h2000_0000 + k);
         push_a(2, 32'h2000_0000 + k);
         #1 check("single_req_ready", 64'(a_ready), 64'b0100);
         step();
      end
      set_a(2, 1'b0, '0);
      #1 check("drain_req_ready", 64'(a_ready), 64'(0));
      step();
      check("drain_valid", 64'(a_chan.valid), 64'(0));

      // Pointer kept at 3 across the drain: 3 wins over 0, then 0.
      set_a(0, 1'b1, 32'hD000_0000);
      set_a(3, 1'b1, 32'hD000_0003);
      push_a(3, 32'hD000_0003);
      #1 check("ptr_hold_ready", 64'(a_ready), 64'b1000);
      step();
      push_a(0, 32'hD000_0000);
      check("ptr_next_ready", 64'(a_ready), 64'b0001);
      step();
      set_a(0, 1'b0, '0);
      set_a(3, 1'b0, '0);
      step();

      // Fairness from a fresh reset: order 0,1,2,3,0,1,2,3.
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < NA; i++) set_a(i, 1'b1, 32'hF000_0000 + i);
      for (int k = 0; k < 8; k++) begin
         push_a(k % NA, 32'hF000_0000 + (k % NA));
         step();
      end
      for (int i = 0; i < NA; i++) set_a(i, 1'b0, '0);
      step();

      // Backpressure: A5 held three cycles, then 3C loads with no bubble.
      set_a(1, 1'b1, 32'h0000_00A5);
      push_a(1, 32'h0000_00A5);
      step();
      set_a(1, 1'b0, '0);
      set_a(3, 1'b1, 32'h0000_003C);
      push_a(3, 32'h0000_003C);
      a_rx.ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("bp_hold_data", 64'(a_chan.data), 64'h00A5);
         check("bp_hold_valid_idx", {62'(a_chan.valid), a_idx}, {62'(1), 2'd1});
         check("bp_req_ready", 64'(a_ready), 64'(0));
         step();
      end
      a_rx.ready = 1'b1;
      #1 check("bp_release_ready", 64'(a_ready), 64'b1000);
      step();
      check("bp_no_bubble", {63'(a_chan.valid), 1'b0} | 64'(a_chan.data), 64'h3C | 64'h2);
      set_a(3, 1'b0, '0);
      step();

      // Reset while FULL and stalled: held beat is discarded.
      set_a(2, 1'b1, 32'h0000_DEAD);
      a_rx.ready = 1'b0;
      step();
      set_a(2, 1'b0, '0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      check("mid_rst_valid", 64'(a_chan.valid), 64'(0));
      check("mid_rst_idx", 64'(a_idx), 64'(0));
      a_rx.ready = 1'b1;
      step();
      step();
      set_a(0, 1'b1, 32'hE000_0000);
      set_a(3, 1'b1, 32'hE000_0003);
      push_a(0, 32'hE000_0000);
      #1 check("mid_rst_ptr_ready", 64'(a_ready), 64'b0001);
      step();
      set_a(0, 1'b0, '0);
      set_a(3, 1'b0, '0);
      step();

      // Three-requester wrap: grant 1 (ptr->2), then 0 (ptr->1), then 1.
      set_b(1, 1'b1, 32'hB000_0001);
      push_b(1, 32'hB000_0001);
      #1 check("wrap_first_ready", 64'(b_ready), 64'b010);
      step();
      set_b(0, 1'b1, 32'hB000_0000);
      push_b(0, 32'hB000_0000);
      #1 check("wrap_ready", 64'(b_ready), 64'b001);
      step();
      push_b(1, 32'hB000_0001);
      check("wrap_ptr_ready", 64'(b_ready), 64'b010);
      step();
      set_b(0, 1'b0, '0);
      set_b(1, 1'b0, '0);
      step();

      for (int k = 0; k < 20 && (qa.size() != 0 || qb.size() != 0); k++) step();
      check("qa_empty", 64'(qa.size()), 64'(0));
      check("qb_empty", 64'(qb.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/eu_icon_arbiter.md
EU_ICON_ARBITER -- requirements
Module: eu_icon_arbiter

Interface
REQ-001 Parameter NUM_REQ, default `NUM_EXEC_UNITS, number of requesting exec units; any value >= 2, not restricted to a power of two.
REQ-002 Parameter DATA_WIDTH, default exec_unit_dtypes::DATA_WIDTH, payload width carried in type_icon_channel.data.
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 i_req  input  NUM_REQ x type_icon_channel  per-requester address/data/valid.
REQ-006 o_req_ready  output  NUM_REQ  per-requester accept; transfer i occurs when i_req[i].valid && o_req_ready[i].
REQ-007 o_chan  output  type_icon_channel  shared registered interconnect output.
REQ-008 i_chan_rx  input  type_icon_rx_channel  downstream ready; beat completes when o_chan.valid && i_chan_rx.ready.
REQ-009 o_grant_idx  output  $clog2(NUM_REQ)  index of the requester whose beat currently sits in o_chan; valid only while o_chan.valid.

Function
REQ-010 Block SHALL contain one output slot register holding o_chan and o_grant_idx; no other data buffering.
REQ-011 FSM SHALL have two states: EMPTY (slot free) and FULL (slot holds a beat).
REQ-012 Slot is loadable in a cycle when state is EMPTY, or state is FULL and i_chan_rx.ready is high (pass-through, no bubble).
REQ-013 When loadable, arbiter SHALL select exactly one valid requester by round-robin starting at pointer rr_ptr, searching rr_ptr, rr_ptr+1, ..., wrapping from NUM_REQ-1 to 0.
REQ-014 o_req_ready SHALL be one-hot on the selected requester when loadable and any request is valid, otherwise all-zero; o_req_ready is combinational from state, i_req valids, i_chan_rx.ready and rr_ptr.
REQ-015 On acceptance of requester g, next cycle: o_chan = i_req[g] captured (valid=1), o_grant_idx = g, state = FULL, rr_ptr = (g+1) mod NUM_REQ.
REQ-016 Latency from accepted request to o_chan.valid SHALL be exactly 1 cycle.
REQ-017 While FULL and i_chan_rx.ready low, o_chan and o_grant_idx SHALL hold stable; all o_req_ready SHALL be 0.
REQ-018 FULL with i_chan_rx.ready high and no valid request: next state EMPTY, o_chan.valid = 0, rr_ptr unchanged.
REQ-019 FULL with i_chan_rx.ready high and a valid request: drain and load in same cycle, state stays FULL; sustained throughput 1 beat/cycle.
REQ-020 EMPTY with no valid request: remain EMPTY, rr_ptr unchanged.
REQ-021 Fairness: with all NUM_REQ requesters continuously valid and ready high, each SHALL be granted exactly once in every NUM_REQ consecutive beats.
REQ-022 A lone continuously-valid requester SHALL be granted every loadable cycle.
REQ-023 o_chan.addr/data are don't-care while o_chan.valid is 0 but SHALL not be X after reset (cleared to 0).
REQ-024 Requester inputs with valid=0 SHALL never influence selection.

Reset
REQ-025 Reset SHALL set state EMPTY, o_chan to all-zero (valid=0), o_grant_idx 0, rr_ptr 0; o_req_ready all-zero during the reset cycle.
REQ-026 Reset asserted while FULL SHALL discard the held beat without completing it; the requester is not re-offered it.
REQ-027 Reset has priority over any simultaneous load/drain in the same cycle.

Structure
REQ-028 type_icon_channel, type_icon_rx_channel and DATA_WIDTH SHALL be used from exec_unit_dtypes; a new localparam LOG2_NUM_REQ and enum type_icon_arb_state {EMPTY, FULL} SHALL be added to that package.
REQ-029 Round-robin search SHALL be a separate combinational sub-module rr_priority_picker (inputs: request vector, pointer; outputs: found, one-hot grant, encoded index).
REQ-030 No latches; all sequential logic in a single clocked process on i_clk.

Verification
REQ-031 Single requester: NUM_REQ=4, only req 2 valid for 5 cycles, ready=1 -> 5 consecutive o_chan beats one cycle later, o_grant_idx=2 each, data matches in order.
REQ-032 All-request fairness: NUM_REQ=4, all valid, ready=1, rr_ptr=0 after reset -> grant order 0,1,2,3,0,1,2,3 over 8 cycles.
REQ-033 Backpressure: beat from req 1 (data 0xA5) in slot, ready=0 for 3 cycles -> o_chan held at 0xA5, o_req_ready=0; ready=1 -> next beat loaded same cycle, no bubble.
REQ-034 Wrap: NUM_REQ=3, rr_ptr=2, valids on 0 and 1 -> grant 0, rr_ptr becomes 1.
REQ-035 Reset mid-operation: FULL with ready=0, assert reset one cycle -> o_chan.valid=0, rr_ptr=0, held beat never appears at output.
REQ-036 Drain to empty: FULL, ready=1, no requests -> o_chan.valid=0 next cycle, state EMPTY, rr_ptr unchanged.
